// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage with load extraction, load timeout and optional forwarding port
// Optional feature: define WB_BYPASS_EN to drive the byp_* forwarding port.
`timescale 1ns/1ps

module wb_stage #(
   parameter int unsigned LD_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_wr_en,
   input  logic        in_is_load,
   input  logic [4:0]  in_rd_addr,
   input  logic [2:0]  in_funct3,
   input  logic [1:0]  in_addr_lo,
   input  logic [31:0] in_alu_result,
   input  logic        ld_rsp_valid,
   input  logic [31:0] ld_rsp_data,
   output logic        reg_wr_en,
   output logic [4:0]  rd_addr,
   output logic [31:0] w_data,
   output logic        ld_timeout,
   output logic [31:0] retired_cnt,
   output logic        byp_valid,
   output logic [4:0]  byp_rd,
   output logic [31:0] byp_data
);

   typedef enum logic {IDLE, WAIT_LD} state_t;

   localparam logic [15:0] CNT_LAST = 16'(LD_TIMEOUT - 1);

   state_t      state, state_nx;
   logic [15:0] wait_cnt, wait_cnt_nx;
   logic        latch_load;
   logic        set_timeout;

   logic [4:0]  l_rd;
   logic [2:0]  l_f3;
   logic [1:0]  l_lo;
   logic        l_wr;

   logic        wb_fire;
   logic        wb_wr;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   assign in_ready = (state == IDLE);

   // Byte lane from the full address offset; halfword lane ignores addr bit 0.
   always_comb begin
      ld_byte = ld_rsp_data[{l_lo, 3'b000} +: 8];
      ld_half = ld_rsp_data[{l_lo[1], 4'b0000} +: 16];
      case (l_f3)
         3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {24'h000000, ld_byte};
         3'b101:  ld_ext = {16'h0000, ld_half};
         default: ld_ext = ld_rsp_data;
      endcase
   end

   always_comb begin
      state_nx    = state;
      wait_cnt_nx = wait_cnt;
      latch_load  = 1'b0;
      set_timeout = 1'b0;
      wb_fire     = 1'b0;
      wb_wr       = 1'b0;
      wb_rd       = 5'd0;
      wb_data     = 32'd0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               if (in_is_load) begin
                  latch_load  = 1'b1;
                  wait_cnt_nx = 16'd0;
                  state_nx    = WAIT_LD;
               end else begin
                  wb_fire = 1'b1;
                  wb_wr   = in_wr_en;
                  wb_rd   = in_rd_addr;
                  wb_data = in_alu_result;
               end
            end
         end
         WAIT_LD: begin
            // A response in the final wait cycle still beats the timeout.
            if (ld_rsp_valid) begin
               wb_fire  = 1'b1;
               wb_wr    = l_wr;
               wb_rd    = l_rd;
               wb_data  = ld_ext;
               state_nx = IDLE;
            end else if (wait_cnt == CNT_LAST) begin
               set_timeout = 1'b1;
               state_nx    = IDLE;
            end else begin
               wait_cnt_nx = wait_cnt + 16'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         wait_cnt <= 16'd0;
         l_rd     <= 5'd0;
         l_f3     <= 3'd0;
         l_lo     <= 2'd0;
         l_wr     <= 1'b0;
      end else begin
         state    <= state_nx;
         wait_cnt <= wait_cnt_nx;
         if (latch_load) begin
            l_rd <= in_rd_addr;
            l_f3 <= in_funct3;
            l_lo <= in_addr_lo;
            l_wr <= in_wr_en;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_wr_en   <= 1'b0;
         rd_addr     <= 5'd0;
         w_data      <= 32'd0;
         ld_timeout  <= 1'b0;
         retired_cnt <= 32'd0;
      end else begin
         reg_wr_en <= wb_fire && wb_wr && (wb_rd != 5'd0);
         if (wb_fire) begin
            rd_addr <= wb_rd;
            w_data  <= wb_data;
         end
         if (set_timeout)
            ld_timeout <= 1'b1;
         if (reg_wr_en)
            retired_cnt <= retired_cnt + 32'd1;
      end
   end

`ifdef WB_BYPASS_EN
   logic        hold_valid;
   logic [4:0]  hold_rd;
   logic [31:0] hold_data;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_rd    <= 5'd0;
         hold_data  <= 32'd0;
      end else begin
         hold_valid <= reg_wr_en;
         if (reg_wr_en) begin
            hold_rd   <= rd_addr;
            hold_data <= w_data;
         end
      end
   end

   // Live write takes priority; otherwise replay the previous write for one cycle.
   assign byp_valid = reg_wr_en | hold_valid;
   assign byp_rd    = (!reg_wr_en && hold_valid) ? hold_rd   : rd_addr;
   assign byp_data  = (!reg_wr_en && hold_valid) ? hold_data : w_data;
`else
   assign byp_valid = 1'b0;
   assign byp_rd    = 5'd0;
   assign byp_data  = 32'd0;
`endif

endmodule
